// File: rtl/ram_2p_be.sv
// True dual-port word RAM with per-byte write enables, read-first on both ports, port A wins overlapping bytes.
// Define RAM_2P_OUTREG_EN to add an output register stage per port (latency 2 instead of 1).
module ram_2p_be #(
  parameter int Depth     = 128,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   a_req_i,
  input  logic                   a_we_i,
  input  logic [DataWidth/8-1:0] a_be_i,
  input  logic [AddrWidth-1:0]   a_addr_i,
  input  logic [DataWidth-1:0]   a_wdata_i,
  output logic                   a_rvalid_o,
  output logic [DataWidth-1:0]   a_rdata_o,
  output logic                   a_err_o,
  input  logic                   b_req_i,
  input  logic                   b_we_i,
  input  logic [DataWidth/8-1:0] b_be_i,
  input  logic [AddrWidth-1:0]   b_addr_i,
  input  logic [DataWidth-1:0]   b_wdata_i,
  output logic                   b_rvalid_o,
  output logic [DataWidth-1:0]   b_rdata_o,
  output logic                   b_err_o,
  output logic                   collision_o
);

  localparam int NumBytes = DataWidth / 8;
  localparam int Ob       = $clog2(NumBytes);
  localparam int Aw       = $clog2(Depth);
  localparam logic [Aw:0] DepthL = (Aw+1)'(Depth);

  logic [DataWidth-1:0] mem_r [Depth];

  logic [Aw-1:0]        a_idx_s, b_idx_s;
  logic                 a_inr_s, b_inr_s;
  logic                 a_wr_s, b_wr_s;
  logic                 coll_s;
  logic                 unused_addr_s;

  logic                 a_rvalid_r, b_rvalid_r;
  logic                 a_err_r, b_err_r;
  logic [DataWidth-1:0] a_rdata_r, b_rdata_r;
  logic                 coll_r;

  // Only the word-index slice of each address is decoded.
  assign unused_addr_s = ^{a_addr_i, b_addr_i};

  // Decode word index, range and effective write strobes for both ports
  always_comb begin
    a_idx_s = a_addr_i[Ob+Aw-1:Ob];
    b_idx_s = b_addr_i[Ob+Aw-1:Ob];
    a_inr_s = ({1'b0, a_idx_s} < DepthL);
    b_inr_s = ({1'b0, b_idx_s} < DepthL);
    a_wr_s  = a_req_i & a_we_i & a_inr_s & ~rst_i;
    b_wr_s  = b_req_i & b_we_i & b_inr_s & ~rst_i;
    coll_s  = a_wr_s & b_wr_s & (a_idx_s == b_idx_s) & (|(a_be_i & b_be_i));
  end

  // Array write: B is applied first so A's bytes take precedence where enables overlap
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (b_wr_s && b_be_i[i]) begin
        mem_r[b_idx_s][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      end
      if (a_wr_s && a_be_i[i]) begin
        mem_r[a_idx_s][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
      end
    end
  end

  // Read-first response stage: old word, range error and collision flag per accepted request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      a_err_r    <= 1'b0;
      b_err_r    <= 1'b0;
      a_rdata_r  <= {DataWidth{1'b0}};
      b_rdata_r  <= {DataWidth{1'b0}};
      coll_r     <= 1'b0;
    end else begin
      a_rvalid_r <= a_req_i;
      b_rvalid_r <= b_req_i;
      a_err_r    <= a_req_i & ~a_inr_s;
      b_err_r    <= b_req_i & ~b_inr_s;
      coll_r     <= coll_s;
      if (a_req_i) begin
        a_rdata_r <= a_inr_s ? mem_r[a_idx_s] : {DataWidth{1'b0}};
      end
      if (b_req_i) begin
        b_rdata_r <= b_inr_s ? mem_r[b_idx_s] : {DataWidth{1'b0}};
      end
    end
  end

`ifdef RAM_2P_OUTREG_EN
  logic                 a_rvalid_p_r, b_rvalid_p_r;
  logic                 a_err_p_r, b_err_p_r;
  logic [DataWidth-1:0] a_rdata_p_r, b_rdata_p_r;
  logic                 coll_p_r;

  // Output register stage; read data only advances with a response so it holds otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rvalid_p_r <= 1'b0;
      b_rvalid_p_r <= 1'b0;
      a_err_p_r    <= 1'b0;
      b_err_p_r    <= 1'b0;
      a_rdata_p_r  <= {DataWidth{1'b0}};
      b_rdata_p_r  <= {DataWidth{1'b0}};
      coll_p_r     <= 1'b0;
    end else begin
      a_rvalid_p_r <= a_rvalid_r;
      b_rvalid_p_r <= b_rvalid_r;
      a_err_p_r    <= a_err_r;
      b_err_p_r    <= b_err_r;
      coll_p_r     <= coll_r;
      if (a_rvalid_r) begin
        a_rdata_p_r <= a_rdata_r;
      end
      if (b_rvalid_r) begin
        b_rdata_p_r <= b_rdata_r;
      end
    end
  end

  assign a_rvalid_o  = a_rvalid_p_r;
  assign a_rdata_o   = a_rdata_p_r;
  assign a_err_o     = a_err_p_r;
  assign b_rvalid_o  = b_rvalid_p_r;
  assign b_rdata_o   = b_rdata_p_r;
  assign b_err_o     = b_err_p_r;
  assign collision_o = coll_p_r;
`else
  assign a_rvalid_o  = a_rvalid_r;
  assign a_rdata_o   = a_rdata_r;
  assign a_err_o     = a_err_r;
  assign b_rvalid_o  = b_rvalid_r;
  assign b_rdata_o   = b_rdata_r;
  assign b_err_o     = b_err_r;
  assign collision_o = coll_r;
`endif

endmodule

// File: tb/tb_ram_2p_be.sv
// Scoreboard bench for ram_2p_be (Depth=100): byte-level model, per-port expected-response queues.
module tb_ram_2p_be;

  localparam int Depth = 100;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int NB    = DW / 8;
`ifdef RAM_2P_OUTREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  typedef struct packed {
    logic          req;
    logic          we;
    logic [NB-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
    logic          coll;
    logic          chkd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [NB-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid, a_err, b_err, coll;

  logic [DW-1:0] mdl [Depth];
  logic [NB-1:0] known [Depth];
  exp_t          qa[$], qb[$];
  int            cyc = 0;
  int            n_total = 0;
  int            n_bad = 0;
  logic          mon_en = 1'b0;
  logic [DW-1:0] la, lb;
  logic          la_ok, lb_ok;

  ram_2p_be #(.Depth(Depth), .DataWidth(DW), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err),
    .collision_o(coll)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic req_t idle();
    idle = '0;
  endfunction

  function automatic req_t rd(input logic [AW-1:0] ad);
    rd = '0;
    rd.req = 1'b1;
    rd.addr = ad;
  endfunction

  function automatic req_t wr(input logic [AW-1:0] ad, input logic [NB-1:0] be, input logic [DW-1:0] d);
    wr.req = 1'b1;
    wr.we = 1'b1;
    wr.be = be;
    wr.addr = ad;
    wr.wd = d;
  endfunction

  function automatic req_t rnd_req();
    int idx;
    case ($urandom_range(0, 2))
      0:       idx = $urandom_range(0, 3);
      1:       idx = $urandom_range(96, 103);
      default: idx = $urandom_range(0, 127);
    endcase
    rnd_req.req  = ($urandom_range(0, 3) != 0);
    rnd_req.we   = $urandom_range(0, 1) == 1;
    rnd_req.be   = NB'($urandom);
    rnd_req.addr = ($urandom & 32'hFFFF_FE00) | (32'(idx) << 2) | ($urandom & 32'h3);
    rnd_req.wd   = $urandom;
  endfunction

  function automatic exp_t predict(input req_t r, input logic cl);
    int idx;
    idx = int'((r.addr >> 2) & 32'd127);
    predict.due  = cyc + Lat;
    predict.coll = cl;
    predict.err  = (idx >= Depth);
    predict.data = '0;
    predict.chkd = 1'b1;
    if (idx < Depth) begin
      predict.data = mdl[idx];
      predict.chkd = &known[idx];
    end
  endfunction

  task automatic mdl_write(input req_t r);
    int idx;
    idx = int'((r.addr >> 2) & 32'd127);
    if (r.req && r.we && idx < Depth) begin
      for (int i = 0; i < NB; i++) begin
        if (r.be[i]) begin
          mdl[idx][i*8 +: 8] = r.wd[i*8 +: 8];
          known[idx][i] = 1'b1;
        end
      end
    end
  endtask

  // one clock: drive both ports, predict responses, update model, step past the edge
  task automatic cycle(input req_t a, input req_t b, input logic r);
    logic cl;
    int ai, bi;
    rst = r;
    a_req = a.req; a_we = a.we; a_be = a.be; a_addr = a.addr; a_wdata = a.wd;
    b_req = b.req; b_we = b.we; b_be = b.be; b_addr = b.addr; b_wdata = b.wd;
    if (r) begin
      while (qa.size() > 0 && qa[$].due > cyc) void'(qa.pop_back());
      while (qb.size() > 0 && qb[$].due > cyc) void'(qb.pop_back());
    end else begin
      ai = int'((a.addr >> 2) & 32'd127);
      bi = int'((b.addr >> 2) & 32'd127);
      cl = a.req && a.we && b.req && b.we && ai == bi && ai < Depth && ((a.be & b.be) != '0);
      if (a.req) qa.push_back(predict(a, cl));
      if (b.req) qb.push_back(predict(b, cl));
      mdl_write(b);
      mdl_write(a);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      la = '0; lb = '0; la_ok = 1'b1; lb_ok = 1'b1;
    end
  endtask

  // response monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    logic va, vb, ce;
    if (mon_en) begin
      ce = 1'b0;
      va = (qa.size() > 0 && qa[0].due == cyc);
      vb = (qb.size() > 0 && qb[0].due == cyc);
      chk_val("a_rvalid", 64'(a_rvalid), 64'(va));
      chk_val("b_rvalid", 64'(b_rvalid), 64'(vb));
      if (va) begin
        e = qa.pop_front();
        ce = ce | e.coll;
        chk_val("a_err", 64'(a_err), 64'(e.err));
        if (e.chkd) chk_val("a_rdata", 64'(a_rdata), 64'(e.data));
        la = e.data; la_ok = e.chkd;
      end else begin
        chk_val("a_err_idle", 64'(a_err), 64'd0);
        if (la_ok) chk_val("a_rdata_hold", 64'(a_rdata), 64'(la));
      end
      if (vb) begin
        e = qb.pop_front();
        ce = ce | e.coll;
        chk_val("b_err", 64'(b_err), 64'(e.err));
        if (e.chkd) chk_val("b_rdata", 64'(b_rdata), 64'(e.data));
        lb = e.data; lb_ok = e.chkd;
      end else begin
        chk_val("b_err_idle", 64'(b_err), 64'd0);
        if (lb_ok) chk_val("b_rdata_hold", 64'(b_rdata), 64'(lb));
      end
      chk_val("collision", 64'(coll), 64'(ce));
    end
  end

  initial begin
    for (int i = 0; i < Depth; i++) begin
      known[i] = '0;
      mdl[i] = '0;
    end
    la = '0; lb = '0; la_ok = 1'b1; lb_ok = 1'b1;
    cycle(idle(), idle(), 1'b1);
    cycle(idle(), idle(), 1'b1);
    mon_en = 1'b1;
    cycle(idle(), idle(), 1'b0);

    for (int i = 0; i < Depth / 2; i++)
      cycle(wr(32'(i * 8), 4'hF, 32'hA000_0000 + 32'(i)),
            wr(32'(i * 8 + 4), 4'hF, 32'hB000_0000 + 32'(i)), 1'b0);

    cycle(wr(32'h1000, 4'hF, 32'hDEAD_BEEF), idle(), 1'b0);
    cycle(idle(), rd(32'h1000), 1'b0);
    cycle(wr(32'h1000, 4'b0011, 32'h1234_5678), idle(), 1'b0);
    cycle(rd(32'h1000), idle(), 1'b0);
    cycle(wr(32'h40, 4'hF, 32'h1111_1111), wr(32'h40, 4'b1100, 32'h2222_2222), 1'b0);
    cycle(rd(32'h40), idle(), 1'b0);
    cycle(wr(32'h40, 4'b0011, 32'h1111_1111), wr(32'h40, 4'b1100, 32'h2222_2222), 1'b0);
    cycle(idle(), rd(32'h40), 1'b0);
    cycle(wr(32'h40, 4'h0, 32'hFFFF_FFFF), rd(32'h8000_0040), 1'b0);
    cycle(wr(32'h190, 4'hF, 32'hBAD0_BAD0), rd(32'h190), 1'b0);
    cycle(rd(32'h0), rd(32'h18C), 1'b0);
    cycle(wr(32'h18C, 4'hF, 32'h9999_9999), rd(32'h1FC), 1'b0);
    cycle(rd(32'h18C), rd(32'h4), 1'b0);
    cycle(idle(), idle(), 1'b0);

    for (int i = 0; i < 16; i++)
      cycle(rd(32'(i * 4)), rd(32'((i + 50) * 4)), i == 8);

    for (int i = 0; i < 300; i++)
      cycle(rnd_req(), rnd_req(), ($urandom_range(0, 49) == 0));

    for (int i = 0; i < 4; i++)
      cycle(idle(), idle(), 1'b0);
    chk_val("drain_a", 64'(qa.size()), 64'd0);
    chk_val("drain_b", 64'(qb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
